// File: rtl/rotating_shift_buffer.sv
// rotating_shift_buffer: loads one vector, then streams rotated/shifted windows
// with valid/ready handshakes on both sides.
module rotating_shift_buffer #(
  parameter int DATA_WIDTH  = 8,
  parameter int BUFFER_SIZE = 16,
  parameter int BEAT_W      = $clog2(BUFFER_SIZE) + 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [BUFFER_SIZE-1:0][DATA_WIDTH-1:0] data_in,
  input  logic                                  data_in_valid,
  output logic                                  data_in_ready,
  input  logic                                  cfg_dir,
  input  logic                                  cfg_fill,
  input  logic [BEAT_W-1:0]                     cfg_beats,
  output logic [BUFFER_SIZE-1:0][DATA_WIDTH-1:0] data_out,
  output logic                                  data_out_valid,
  input  logic                                  data_out_ready,
  output logic                                  data_out_last,
  output logic [$clog2(BUFFER_SIZE)-1:0]        beat_idx
);

  localparam int IDX_W = $clog2(BUFFER_SIZE);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  typedef logic [BUFFER_SIZE-1:0][DATA_WIDTH-1:0] vec_t;

  logic [0:0]       state_q, state_d;
  vec_t             bank_q, bank_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             dir_q, dir_d;
  logic             fill_q, fill_d;
  logic [BEAT_W-1:0] eff_q, eff_d;
  logic             valid_q, valid_d;
  logic             rdy_q, rdy_d;

  logic             load;
  logic             fire;
  logic             at_last;
  logic [BEAT_W-1:0] eff_in;
  vec_t             up_v;
  vec_t             dn_v;
  vec_t             shifted;

  assign load    = data_in_valid && rdy_q;
  assign fire    = valid_q && data_out_ready;
  assign at_last = ({1'b0, idx_q} == (eff_q - BEAT_W'(1)));

  // Effective beat count: 0 or oversize requests mean a full revolution
  always_comb begin
    eff_in = cfg_beats;
    if (cfg_beats == '0 || cfg_beats > BEAT_W'(BUFFER_SIZE))
      eff_in = BEAT_W'(BUFFER_SIZE);
  end

  // One-position move of the bank in the latched direction
  always_comb begin
    up_v = '0;
    dn_v = '0;
    for (int i = 1; i < BUFFER_SIZE; i++)
      up_v[i] = bank_q[i-1];
    up_v[0] = fill_q ? '0 : bank_q[BUFFER_SIZE-1];
    for (int i = 0; i < BUFFER_SIZE - 1; i++)
      dn_v[i] = bank_q[i+1];
    dn_v[BUFFER_SIZE-1] = fill_q ? '0 : bank_q[0];
    shifted = dir_q ? dn_v : up_v;
  end

  // Load / stream sequencing
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    fill_d  = fill_q;
    eff_d   = eff_q;
    valid_d = valid_q;
    rdy_d   = rdy_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          bank_d  = data_in;
          dir_d   = cfg_dir;
          fill_d  = cfg_fill;
          eff_d   = eff_in;
          idx_d   = '0;
          state_d = STREAM;
          valid_d = 1'b1;
          rdy_d   = 1'b0;
        end
      end
      STREAM: begin
        if (fire) begin
          if (at_last) begin
            state_d = IDLE;
            valid_d = 1'b0;
            rdy_d   = 1'b1;
            idx_d   = '0;
          end else begin
            bank_d = shifted;
            idx_d  = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        rdy_d   = 1'b1;
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bank_q  <= '0;
      idx_q   <= '0;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
      eff_q   <= BEAT_W'(BUFFER_SIZE);
      valid_q <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
      eff_q   <= eff_d;
      valid_q <= valid_d;
      rdy_q   <= rdy_d;
    end
  end

  assign data_out       = bank_q;
  assign data_out_valid = valid_q;
  assign data_in_ready  = rdy_q;
  assign beat_idx       = idx_q;
  assign data_out_last  = (state_q == STREAM) && at_last;

endmodule

// File: doc/rotating_shift_buffer.md
# rotating_shift_buffer

Parametrised circular shift buffer with valid/ready handshakes on both sides. It accepts one parallel vector of BUFFER_SIZE words, then emits a programmable number of output beats; each beat is the vector rotated, or shifted with zero fill, by one further position in a programmable direction. It feeds rotated operand windows to downstream compute, such as systolic or convolution-style datapaths, and supersedes the fixed-depth free-running shift register.

## Interface
- DATA_WIDTH, 8, bits per word
- BUFFER_SIZE, 16, words per vector; legal range ≥ 2
- BEAT_W, $clog2(BUFFER_SIZE)+1, width of cfg_beats (derived; do not override)
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, asynchronous, active-low (asserted when 0)
- data_in  input  DATA_WIDTH x [BUFFER_SIZE]  parallel load vector
- data_in_valid  input  1  load request
- data_in_ready  output  1  buffer idle; load accepted on valid&&ready
- cfg_dir  input  1  0: up (new[i]=old[i-1]); 1: down (new[i]=old[i+1])
- cfg_fill  input  1  0: circular rotate; 1: vacated slot loads 0
- cfg_beats  input  BEAT_W  beats to emit; 0 or >BUFFER_SIZE means BUFFER_SIZE
- data_out  output  DATA_WIDTH x [BUFFER_SIZE]  current window (register bank)
- data_out_valid  output  1  window valid
- data_out_ready  input  1  consumer accepts beat
- data_out_last  output  1  current beat is final beat
- beat_idx  output  $clog2(BUFFER_SIZE)  index of current beat, 0-based

## Operation
- States: IDLE and STREAM.
- IDLE:
  - data_in_ready=1, data_out_valid=0.
  - On data_in_valid&&data_in_ready: capture data_in into the bank, latch cfg_dir/cfg_fill/effective beats, set beat_idx=0, go to STREAM.
- STREAM:
  - data_in_ready=0; data_in_valid is ignored.
  - data_out_valid=1; data_out = bank.
  - Beat 0 is the unrotated loaded vector.
- Beat handshake (data_out_valid&&data_out_ready):
  - Non-last beat: bank shifts one position per latched direction; beat_idx++.
  - Last beat: go to IDLE; bank keeps the last window; beat_idx=0.
- Shift rules:
  - Up: new[0]=old[BUFFER_SIZE-1], or 0 if fill.
  - Down: new[BUFFER_SIZE-1]=old[0], or 0 if fill.
- data_out_last = STREAM && (beat_idx == effective_beats-1).
- Backpressure: while valid&&!ready, the bank, beat_idx and data_out_last hold.
- Config inputs are sampled only at the load handshake; changes during STREAM have no effect.
- Reset (rst=0, asynchronous, any state, including mid-stream):
  - Bank = 0, state = IDLE, data_out_valid=0, data_out_last=0, beat_idx=0, data_in_ready=1.
  - Latched config = up / rotate / BUFFER_SIZE.

## Timing
- All outputs are registered, except data_out_last, which is decoded from registers only.
- Load latency: handshake at edge N, so data_out_valid=1 with beat 0 after edge N.
- With data_out_ready held 1, one beat per cycle; an E-beat vector occupies exactly E cycles of valid.
- Turnaround: data_in_ready rises the cycle after the last-beat handshake, giving 1 idle cycle between vectors.
  - No combinational ready path.
  - Sustained throughput is E beats per E+1 cycles.
- Reset assertion affects outputs immediately (asynchronous). Release is synchronous-safe; the first load is accepted at the first edge with rst=1.

## Test plan
Test configuration: BUFFER_SIZE=4, DATA_WIDTH=8, data_in[0..3]={1,2,3,4}.

- **Rotate up, full length:** cfg_dir=0, cfg_fill=0, cfg_beats=0, data_out_ready=1.
  - Beats: {1,2,3,4}, {4,1,2,3}, {3,4,1,2}, {2,3,4,1}; data_out_last only on beat 3; beat_idx 0..3.
  - data_in_ready returns 1 exactly one cycle after the last beat.
- **Zero fill down:** cfg_dir=1, cfg_fill=1, cfg_beats=3.
  - Beats: {1,2,3,4}, {2,3,4,0}, {3,4,0,0}; last=1 on the third beat.
- **Backpressure:** during test 1, hold data_out_ready=0 for 3 cycles at beat 1.
  - data_out stays {4,1,2,3}, valid=1, beat_idx=1 throughout.
  - The sequence resumes unchanged after release.
- **Load during STREAM:** data_in_valid=1 with {9,9,9,9} while streaming.
  - data_in_ready=0 and the vector is ignored.
  - The output sequence matches test 1.
  - {9,9,9,9} is accepted only once IDLE.
- **Reset mid-stream:** drive rst=0 at beat 2.
  - Same cycle: data_out_valid=0, data_out={0,0,0,0}, data_in_ready=1.
  - After release, a new load of {5,6,7,8} with cfg_beats=1 yields a single beat {5,6,7,8} with last=1.
- **Config change mid-stream:** toggle cfg_dir/cfg_fill/cfg_beats during test 1.
  - Output is identical to test 1.
